// File: rtl/hazard_scanner.sv
// Hazard scanner: buffers a block of instructions, then walks every (i,j) pair
// within WINDOW and reports RAW/WAR/WAW dependencies over a valid/ready port.
module hazard_scanner #(
   parameter  int REG_W   = 3,
   parameter  int DEPTH   = 8,
   parameter  int WINDOW  = 7,
   localparam int IDX_W   = $clog2(DEPTH),
   localparam int INSTR_W = 3*REG_W + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_last,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic [1:0]         rpt_type,
   output logic [IDX_W-1:0]   rpt_i,
   output logic [IDX_W-1:0]   rpt_j,
   output logic               done,
   output logic [7:0]         hz_count
);

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] T_RAW = 2'b10;
   localparam logic [1:0] T_WAR = 2'b01;
   localparam logic [1:0] T_WAW = 2'b11;

   // Counters carry one extra bit so that n == DEPTH and i+2 never wrap.
   localparam int               CNT_W     = IDX_W + 1;
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] WIN       = CNT_W'(WINDOW);

   logic [1:0]         state;
   logic [INSTR_W-1:0] buf_mem [DEPTH];
   logic [CNT_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   n_cnt;
   logic [CNT_W-1:0]   idx_i;
   logic [CNT_W-1:0]   idx_j;

   logic [INSTR_W-1:0] ins_i, ins_j;
   logic               wr_i, wr_j;
   logic [REG_W-1:0]   dst_i, src1_i, src2_i;
   logic [REG_W-1:0]   dst_j, src1_j, src2_j;
   logic [2:0]         pair_hz_p0;
   logic [2:0]         pend_p1;
   logic [2:0]         sel;
   logic [2:0]         pend_next;
   logic               accept, fire;
   logic [CNT_W-1:0]   j_inc, i_inc, i_j2;
   logic               step_j, step_i;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign in_ready = (state == S_LOAD);
   assign done     = (state == S_DONE);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (accept && !clr)
         buf_mem[wr_ptr[IDX_W-1:0]] <= in_instr;
   end

   // Stage p0: decode the current pair straight out of the buffer.
   assign ins_i = buf_mem[idx_i[IDX_W-1:0]];
   assign ins_j = buf_mem[idx_j[IDX_W-1:0]];

   assign {wr_i, dst_i, src1_i, src2_i} = ins_i;
   assign {wr_j, dst_j, src1_j, src2_j} = ins_j;

   assign pair_hz_p0[2] = wr_i & ((dst_i == src1_j) | (dst_i == src2_j));
   assign pair_hz_p0[1] = wr_j & ((dst_j == src1_i) | (dst_j == src2_i));
   assign pair_hz_p0[0] = wr_i & wr_j & (dst_i == dst_j);

   // Stage p1: registered flags drained one report at a time, RAW first.
   always_comb begin
      rpt_type = T_RAW;
      sel      = 3'b000;
      if (pend_p1[2]) begin
         rpt_type = T_RAW;
         sel      = 3'b100;
      end else if (pend_p1[1]) begin
         rpt_type = T_WAR;
         sel      = 3'b010;
      end else if (pend_p1[0]) begin
         rpt_type = T_WAW;
         sel      = 3'b001;
      end
   end

   assign rpt_valid = (state == S_EMIT) & (|pend_p1);
   assign fire      = rpt_valid & rpt_ready;
   assign pend_next = pend_p1 & ~(fire ? sel : 3'b000);
   assign rpt_i     = idx_i[IDX_W-1:0];
   assign rpt_j     = idx_j[IDX_W-1:0];

   assign j_inc  = idx_j + ONE;
   assign i_inc  = idx_i + ONE;
   assign i_j2   = idx_i + TWO;
   assign step_j = (j_inc < n_cnt) && ((j_inc - idx_i) <= WIN);
   assign step_i = (i_j2 < n_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_LOAD;
         wr_ptr   <= '0;
         n_cnt    <= '0;
         idx_i    <= '0;
         idx_j    <= ONE;
         pend_p1  <= 3'b000;
         hz_count <= 8'd0;
      end else if (clr) begin
         state    <= S_LOAD;
         wr_ptr   <= '0;
         idx_i    <= '0;
         idx_j    <= ONE;
         pend_p1  <= 3'b000;
         hz_count <= 8'd0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid) begin
                  wr_ptr <= wr_ptr + ONE;
                  if (wr_ptr == '0)
                     hz_count <= 8'd0;
                  if (in_last || (wr_ptr == LAST_SLOT)) begin
                     n_cnt <= wr_ptr + ONE;
                     idx_i <= '0;
                     idx_j <= ONE;
                     state <= S_EVAL;
                  end
               end
            end
            S_EVAL: begin
               if (n_cnt < TWO) begin
                  state <= S_DONE;
               end else begin
                  pend_p1 <= pair_hz_p0;
                  state   <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (fire) begin
                  hz_count <= sat_inc(hz_count);
                  pend_p1  <= pend_next;
               end
               // The last handshake of a pair also advances the pair.
               if (pend_next == 3'b000) begin
                  if (step_j) begin
                     idx_j <= j_inc;
                     state <= S_EVAL;
                  end else if (step_i) begin
                     idx_i <= i_inc;
                     idx_j <= i_j2;
                     state <= S_EVAL;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               wr_ptr <= '0;
               state  <= S_LOAD;
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_scanner.sv
// Scoreboard bench: two scanners (WINDOW 7 and 2) share stimulus; a pair-rule
// model predicts each report stream, a monitor pops and compares on handshakes.
module tb_hazard_scanner;

   localparam int REG_W   = 3;
   localparam int DEPTH   = 8;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int INSTR_W = 3*REG_W + 1;
   localparam int WIN_A   = 7;
   localparam int WIN_B   = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               clr = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic               rpt_ready = 1'b0;
   logic [INSTR_W-1:0] in_instr = '0;

   logic             in_ready_a, rpt_valid_a, done_a;
   logic [1:0]       rpt_type_a;
   logic [IDX_W-1:0] rpt_i_a, rpt_j_a;
   logic [7:0]       hz_a;
   logic             in_ready_b, rpt_valid_b, done_b;
   logic [1:0]       rpt_type_b;
   logic [IDX_W-1:0] rpt_i_b, rpt_j_b;
   logic [7:0]       hz_b;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int blk [DEPTH];
   int blk_n = 0;
   int exp_a[$], exp_b[$], dn_a[$], dn_b[$], lt_a[$], lt_b[$];
   bit st_prev [2];
   int st_enc [2];
   int st_hz [2];
   bit dn_prev [2];
   bit dseen [2];
   int pend_hz [2];
   int last_hz [2];
   bit have_last = 1'b0;
   bit rr_mode = 1'b0;

   hazard_scanner #(.REG_W(REG_W), .DEPTH(DEPTH), .WINDOW(WIN_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_last(in_last),
      .rpt_valid(rpt_valid_a), .rpt_ready(rpt_ready), .rpt_type(rpt_type_a),
      .rpt_i(rpt_i_a), .rpt_j(rpt_j_a), .done(done_a), .hz_count(hz_a)
   );

   hazard_scanner #(.REG_W(REG_W), .DEPTH(DEPTH), .WINDOW(WIN_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_last(in_last),
      .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready), .rpt_type(rpt_type_b),
      .rpt_i(rpt_i_b), .rpt_j(rpt_j_b), .done(done_b), .hz_count(hz_b)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(posedge clk); #1;
      if (rr_mode) rpt_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int mk(input int wr, input int dst, input int s1, input int s2);
      return (wr << (3*REG_W)) | (dst << (2*REG_W)) | (s1 << REG_W) | s2;
   endfunction

   // k: 0=src2, 1=src1, 2=dst, 3=wr
   function automatic int fld(input int x, input int k);
      return (x >> (k*REG_W)) % (1 << REG_W);
   endfunction

   task automatic push(input int d, input int v);
      if (d == 0) exp_a.push_back(v); else exp_b.push_back(v);
   endtask

   // Report code = 256*type + 16*i + j, pairs enumerated in ascending (i,j).
   task automatic model(input int win, input int d, output int nr, output int np, output int nh);
      int a, b, cnt;
      bit raw, war, waw;
      nr = 0; np = 0; nh = 0;
      for (int i = 0; i < blk_n; i++) begin
         for (int j = i + 1; j < blk_n && j - i <= win; j++) begin
            a = blk[i];
            b = blk[j];
            raw = (fld(a, 3) == 1) && (fld(a, 2) == fld(b, 1) || fld(a, 2) == fld(b, 0));
            war = (fld(b, 3) == 1) && (fld(b, 2) == fld(a, 1) || fld(b, 2) == fld(a, 0));
            waw = (fld(a, 3) == 1) && (fld(b, 3) == 1) && (fld(a, 2) == fld(b, 2));
            np++;
            if (raw) push(d, 256*2 + 16*i + j);
            if (war) push(d, 256*1 + 16*i + j);
            if (waw) push(d, 256*3 + 16*i + j);
            cnt = int'(raw) + int'(war) + int'(waw);
            nr += cnt;
            if (cnt > 0) nh++;
         end
      end
   endtask

   task automatic mon(input int d, input logic v, input logic [1:0] t, input logic [IDX_W-1:0] ri,
                      input logic [IDX_W-1:0] rj, input logic dn, input logic [7:0] hz);
      int enc, e, sz, lat, left;
      string s;
      s = (d == 0) ? "a" : "b";
      enc = 256*int'(t) + 16*int'(ri) + int'(rj);
      if (st_prev[d] && v) begin
         chk({"stall_fields_", s}, enc, st_enc[d]);
         chk({"stall_hz_", s}, int'(hz), st_hz[d]);
      end
      if (v && rpt_ready) begin
         sz = (d == 0) ? exp_a.size() : exp_b.size();
         if (sz == 0) chk({"rpt_extra_", s}, enc, -1);
         else begin
            if (d == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
            chk({"rpt_", s}, enc, e);
         end
      end
      st_prev[d] = v && !rpt_ready;
      st_enc[d]  = enc;
      st_hz[d]   = int'(hz);
      if (dn) begin
         chk({"done_pulse_", s}, int'(dn_prev[d]), 0);
         sz = (d == 0) ? dn_a.size() : dn_b.size();
         if (sz == 0) chk({"done_extra_", s}, 1, 0);
         else begin
            if (d == 0) begin
               e = dn_a.pop_front(); lat = lt_a.pop_front(); left = exp_a.size();
            end else begin
               e = dn_b.pop_front(); lat = lt_b.pop_front(); left = exp_b.size();
            end
            chk({"hz_done_", s}, int'(hz), e);
            chk({"rpt_missing_", s}, left, 0);
            if (lat >= 0) chk({"latency_", s}, cyc - acc_cyc, lat);
         end
         dseen[d] = 1'b1;
      end
      dn_prev[d] = dn;
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         mon(0, rpt_valid_a, rpt_type_a, rpt_i_a, rpt_j_a, done_a, hz_a);
         mon(1, rpt_valid_b, rpt_type_b, rpt_i_b, rpt_j_b, done_b, hz_b);
      end else begin
         st_prev[0] = 1'b0; st_prev[1] = 1'b0;
         dn_prev[0] = 1'b0; dn_prev[1] = 1'b0;
      end
   end

   task automatic flush();
      exp_a.delete(); exp_b.delete();
      dn_a.delete();  dn_b.delete();
      lt_a.delete();  lt_b.delete();
      st_prev[0] = 1'b0; st_prev[1] = 1'b0;
      have_last = 1'b0;
   endtask

   task automatic wait_dones();
      int t = 0;
      while (!(dseen[0] && dseen[1]) && t < 3000) begin @(posedge clk); t++; end
      #1;
      if (t >= 3000) chk("done_timeout", 0, 1);
      else begin
         have_last = 1'b1;
         last_hz   = pend_hz;
      end
   endtask

   task automatic wait_hz(input int target);
      int t = 0;
      while (int'(hz_a) < target && t < 500) begin @(posedge clk); #1; t++; end
      chk("hz_reach_timeout", int'(t < 500), 1);
   endtask

   task automatic send_block(input int n, input bit lst, input bit gaps, input bit clat, input bit wdone);
      int nr, np, nh;
      blk_n = n;
      model(WIN_A, 0, nr, np, nh);
      pend_hz[0] = (nr > 255) ? 255 : nr;
      dn_a.push_back(pend_hz[0]);
      lt_a.push_back(clat ? ((n < 2) ? 1 : 2*np + nr - nh) : -1);
      model(WIN_B, 1, nr, np, nh);
      pend_hz[1] = (nr > 255) ? 255 : nr;
      dn_b.push_back(pend_hz[1]);
      lt_b.push_back(clat ? ((n < 2) ? 1 : 2*np + nr - nh) : -1);
      dseen[0] = 1'b0; dseen[1] = 1'b0;
      if (have_last) begin
         chk("hz_hold_a", int'(hz_a), last_hz[0]);
         chk("hz_hold_b", int'(hz_b), last_hz[1]);
      end
      for (int k = 0; k < n; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_instr = INSTR_W'(blk[k]);
         in_last  = lst && (k == n - 1);
         @(negedge clk);
         chk("accept_ready_a", int'(in_ready_a), 1);
         chk("accept_ready_b", int'(in_ready_b), 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      acc_cyc = cyc;
      chk("ready_drop_a", int'(in_ready_a), 0);
      chk("ready_drop_b", int'(in_ready_b), 0);
      if (wdone) wait_dones();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready_a"}, int'(in_ready_a), 1);
      chk({tag, "_rpt_valid_a"}, int'(rpt_valid_a), 0);
      chk({tag, "_done_a"}, int'(done_a), 0);
      chk({tag, "_hz_a"}, int'(hz_a), 0);
      chk({tag, "_in_ready_b"}, int'(in_ready_b), 1);
      chk({tag, "_rpt_valid_b"}, int'(rpt_valid_b), 0);
      chk({tag, "_done_b"}, int'(done_b), 0);
      chk({tag, "_hz_b"}, int'(hz_b), 0);
   endtask

   initial begin
      int t;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      rr_mode = 1'b0;
      rpt_ready = 1'b1;

      // Single RAW between two writers.
      blk[0] = mk(1, 3, 1, 2); blk[1] = mk(1, 4, 3, 0);
      send_block(2, 1'b1, 1'b0, 1'b1, 1'b1);

      // RAW followed by WAW on the same pair.
      blk[0] = mk(1, 5, 1, 2); blk[1] = mk(1, 5, 5, 0);
      send_block(2, 1'b1, 1'b0, 1'b1, 1'b1);

      // Eight non-writers, buffer fills without in_last.
      for (int k = 0; k < DEPTH; k++)
         blk[k] = mk(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      send_block(DEPTH, 1'b0, 1'b0, 1'b1, 1'b1);

      // Distance-3 RAW: seen by WINDOW=7, outside WINDOW=2.
      blk[0] = mk(1, 1, 2, 2); blk[1] = mk(0, 0, 0, 0);
      blk[2] = mk(0, 0, 0, 0); blk[3] = mk(0, 0, 1, 1);
      send_block(4, 1'b1, 1'b0, 1'b1, 1'b1);

      // Back-pressure on the first report for ten cycles.
      rpt_ready = 1'b0;
      blk[0] = mk(1, 3, 1, 2); blk[1] = mk(1, 4, 3, 0);
      send_block(2, 1'b1, 1'b0, 1'b0, 1'b0);
      t = 0;
      while (!rpt_valid_a && t < 100) begin @(posedge clk); #1; t++; end
      chk("stall_valid_a", int'(rpt_valid_a), 1);
      repeat (10) begin @(posedge clk); #1; end
      chk("stall_hz_held_a", int'(hz_a), 0);
      chk("stall_valid_held_b", int'(rpt_valid_b), 1);
      rpt_ready = 1'b1;
      wait_dones();

      // One instruction only.
      blk[0] = mk(1, 2, 2, 2);
      send_block(1, 1'b1, 1'b0, 1'b1, 1'b1);

      repeat (40) begin
         int n, rmax;
         bit lst;
         n    = $urandom_range(1, DEPTH);
         lst  = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         rmax = ($urandom_range(0, 1) == 1) ? 1 : 7;
         for (int k = 0; k < n; k++)
            blk[k] = mk($urandom_range(0, 1), $urandom_range(0, rmax),
                        $urandom_range(0, rmax), $urandom_range(0, rmax));
         rr_mode = ($urandom_range(0, 1) == 1);
         if (!rr_mode) rpt_ready = 1'b1;
         send_block(n, lst, 1'b1, !rr_mode, 1'b1);
      end
      rr_mode = 1'b0;
      rpt_ready = 1'b1;

      // Soft clear in the middle of a scan.
      for (int k = 0; k < DEPTH; k++) blk[k] = mk(1, 1, 1, 1);
      send_block(DEPTH, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_hz(3);
      rpt_ready = 1'b0;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      flush();
      chk_idle("clr");
      repeat (5) begin @(posedge clk); #1; end
      chk("clr_stay_load_a", int'(in_ready_a), 1);

      // Asynchronous reset in the middle of a scan.
      rpt_ready = 1'b1;
      send_block(DEPTH, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_hz(2);
      rpt_ready = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      flush();
      chk_idle("arst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rpt_ready = 1'b1;

      blk[0] = mk(1, 5, 1, 2); blk[1] = mk(1, 5, 5, 0); blk[2] = mk(1, 2, 5, 5);
      send_block(3, 1'b1, 1'b0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
